// File: rtl/xccela_bridge_pkg.sv
// Shared types and constants for the Xccela/OPI PSRAM controller bridge:
// FSM states, controller command codes and AXI response codes.
package xccela_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } bridge_state_e;

    localparam logic [7:0] CMD_INIT = 8'h00;
    localparam logic [7:0] CMD_GRST = 8'h80;
    localparam logic [7:0] CMD_MRW  = 8'h01;
    localparam logic [7:0] CMD_MRR  = 8'h02;
    localparam logic [7:0] CMD_WR   = 8'h04;
    localparam logic [7:0] CMD_RD   = 8'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // core = {~rw_n, target, ~type, 3'b000, gb_rst, mem_init}
    function automatic logic [7:0] encode_cmd(input logic [7:0] core);
        logic [7:0] cmd;
        case (core)
            8'hC1:   cmd = CMD_INIT;
            8'hC2:   cmd = CMD_GRST;
            8'hC0:   cmd = CMD_MRW;
            8'h40:   cmd = CMD_MRR;
            8'h80:   cmd = CMD_WR;
            8'h00:   cmd = CMD_RD;
            default: cmd = CMD_INIT;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/xccela_rx_fifo.sv
// Synchronous read-data FIFO; absorbs controller read bursts while the AXI
// read channel is back-pressured. DEPTH must be a power of 2.
module xccela_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rd_en = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves the same cycle.
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
            else if (rd_en && !wr_en) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/xccela_ctrl_bridge.sv
// Bridge from the AXI-side request/TX/RX front end to the Xccela/OPI PSRAM
// controller instruction interface, with read buffering and stall recovery.
module xccela_ctrl_bridge
    import xccela_bridge_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int LEN_W          = 9,
    parameter int RX_FIFO_DEPTH  = 8,
    parameter int RX_ADDR_WIDTH  = 1,
    parameter int TIMEOUT_MARGIN = 20,
    localparam int MASK_W        = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw_n,
    input  logic                     req_target,
    input  logic                     req_type,
    input  logic                     req_gb_rst,
    input  logic                     req_mem_init,
    input  logic [LEN_W-1:0]         req_len,
    input  logic [30:0]              req_addr,
    input  logic [1:0]               req_error,
    input  logic                     req_done_request,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic [MASK_W-1:0]        tx_mask,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [DATA_W-1:0]        rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_last,
    output logic [1:0]               rx_error,
    output logic                     rx_stall,
    output logic [RX_ADDR_WIDTH-1:0] rx_addr,
    output logic                     wr_done,
    output logic                     bd_instruction_req,
    input  logic                     bd_instruction_ready,
    output logic [7:0]               bd_command,
    output logic [31:0]              bd_address,
    output logic [LEN_W-1:0]         bd_data_len,
    output logic [DATA_W-1:0]        bd_wdata,
    output logic [MASK_W-1:0]        bd_wdata_mask,
    input  logic                     bd_wdata_ready,
    input  logic                     bd_rdata_valid,
    input  logic [DATA_W-1:0]        bd_rdata
);
    localparam int TW = LEN_W + 2;

    bridge_state_e     state_q;
    logic [30:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [LEN_W-1:0]  pop_cnt_q;
    logic [1:0]        err_q;
    logic              done_req_q;
    logic              rw_n_q;
    logic [7:0]        cmd_q;
    logic              instr_req_q;
    logic              wr_done_q;
    logic              timeout_q;
    logic              ovf_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic [TW-1:0]     tmo_cnt_d;
    logic [TW-1:0]     tmo_limit;

    logic              in_read;
    logic              beat_in;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              rx_fire;
    logic              tx_fire;

    assign in_read   = (state_q == READ);
    // Once stalled, late controller beats are ignored so synthetic beats stay in order.
    assign beat_in   = in_read & bd_rdata_valid & ~timeout_q;
    assign fifo_pop  = in_read & ~fifo_empty & rx_ready;
    assign fifo_push = beat_in & (~fifo_full | fifo_pop);

    assign tmo_limit = {2'b00, len_q} + TW'(TIMEOUT_MARGIN);
    assign tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    assign req_ready = (state_q == IDLE);
    assign tx_ready  = (state_q == WRITE) & bd_wdata_ready;
    assign tx_fire   = tx_valid & tx_ready;

    assign rx_valid  = in_read & (~fifo_empty | timeout_q);
    assign rx_fire   = rx_valid & rx_ready;
    assign rx_data   = (in_read & ~fifo_empty) ? fifo_dout : '0;
    assign rx_last   = rx_valid & (pop_cnt_q == len_q);
    assign rx_error  = (ovf_q | timeout_q) ? RESP_SLVERR : err_q;
    assign rx_stall  = timeout_q;
    assign rx_addr   = addr_q[RX_ADDR_WIDTH-1:0] + pop_cnt_q[RX_ADDR_WIDTH-1:0];

    assign wr_done            = wr_done_q;
    assign bd_instruction_req = instr_req_q;
    assign bd_command         = cmd_q;
    assign bd_address         = {1'b0, addr_q};
    assign bd_data_len        = len_q;
    assign bd_wdata           = tx_data;
    assign bd_wdata_mask      = tx_mask;

    xccela_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (bd_rdata),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (fifo_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            pop_cnt_q   <= '0;
            err_q       <= '0;
            done_req_q  <= 1'b0;
            rw_n_q      <= 1'b0;
            cmd_q       <= '0;
            instr_req_q <= 1'b0;
            wr_done_q   <= 1'b0;
            timeout_q   <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        len_q       <= req_len;
                        err_q       <= req_error;
                        done_req_q  <= req_done_request;
                        rw_n_q      <= req_rw_n;
                        cmd_q       <= encode_cmd({~req_rw_n, req_target, ~req_type, 3'b000,
                                                   req_gb_rst, req_mem_init});
                        beat_cnt_q  <= '0;
                        pop_cnt_q   <= '0;
                        instr_req_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bd_instruction_ready) begin
                        instr_req_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= rw_n_q ? READ : WRITE;
                    end
                end
                WRITE: begin
                    if (tx_fire) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == len_q) begin
                            wr_done_q <= done_req_q;
                            state_q   <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (beat_in) begin
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                        if (tmo_cnt_d > tmo_limit) timeout_q <= 1'b1;
                    end
                    if (beat_in && fifo_full && !fifo_pop) ovf_q <= 1'b1;
                    // Final beat: sticky flags are cleared here so the next transfer starts clean.
                    if (rx_fire) begin
                        pop_cnt_q <= pop_cnt_q + 1'b1;
                        if (pop_cnt_q == len_q) begin
                            timeout_q <= 1'b0;
                            ovf_q     <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xccela_ctrl_bridge.sv
// Directed bench for xccela_ctrl_bridge: writes, buffered reads, overflow
// with a 4-deep FIFO, stalled-read recovery, command encoding and mid-write reset.
module tb_xccela_ctrl_bridge;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 9;
    localparam int MASK_W = 2;
    localparam int MARGIN = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid, req_rw_n, req_target, req_type, req_gb_rst, req_mem_init;
    logic [LEN_W-1:0]  req_len;
    logic [30:0]       req_addr;
    logic [1:0]        req_error;
    logic              req_done_request;
    logic [DATA_W-1:0] tx_data;
    logic [MASK_W-1:0] tx_mask;
    logic              tx_valid, rx_ready;
    logic              bd_instruction_ready, bd_wdata_ready, bd_rdata_valid;
    logic [DATA_W-1:0] bd_rdata;

    // depth-8 instance outputs
    logic              req_ready, tx_ready, rx_valid, rx_last, rx_stall, wr_done, bd_instruction_req;
    logic [DATA_W-1:0] rx_data, bd_wdata;
    logic [1:0]        rx_error;
    logic [0:0]        rx_addr;
    logic [7:0]        bd_command;
    logic [31:0]       bd_address;
    logic [LEN_W-1:0]  bd_data_len;
    logic [MASK_W-1:0] bd_wdata_mask;

    // depth-4 instance outputs
    logic              req_ready4, tx_ready4, rx_valid4, rx_last4, rx_stall4, wr_done4, bd_instruction_req4;
    logic [DATA_W-1:0] rx_data4, bd_wdata4;
    logic [1:0]        rx_error4;
    logic [0:0]        rx_addr4;
    logic [7:0]        bd_command4;
    logic [31:0]       bd_address4;
    logic [LEN_W-1:0]  bd_data_len4;
    logic [MASK_W-1:0] bd_wdata_mask4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xccela_ctrl_bridge #(.DATA_W(DATA_W), .LEN_W(LEN_W), .RX_FIFO_DEPTH(8),
                         .RX_ADDR_WIDTH(1), .TIMEOUT_MARGIN(MARGIN)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw_n(req_rw_n),
        .req_target(req_target), .req_type(req_type), .req_gb_rst(req_gb_rst),
        .req_mem_init(req_mem_init), .req_len(req_len), .req_addr(req_addr),
        .req_error(req_error), .req_done_request(req_done_request),
        .tx_data(tx_data), .tx_mask(tx_mask), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last),
        .rx_error(rx_error), .rx_stall(rx_stall), .rx_addr(rx_addr), .wr_done(wr_done),
        .bd_instruction_req(bd_instruction_req), .bd_instruction_ready(bd_instruction_ready),
        .bd_command(bd_command), .bd_address(bd_address), .bd_data_len(bd_data_len),
        .bd_wdata(bd_wdata), .bd_wdata_mask(bd_wdata_mask), .bd_wdata_ready(bd_wdata_ready),
        .bd_rdata_valid(bd_rdata_valid), .bd_rdata(bd_rdata)
    );

    xccela_ctrl_bridge #(.DATA_W(DATA_W), .LEN_W(LEN_W), .RX_FIFO_DEPTH(4),
                         .RX_ADDR_WIDTH(1), .TIMEOUT_MARGIN(MARGIN)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready4), .req_rw_n(req_rw_n),
        .req_target(req_target), .req_type(req_type), .req_gb_rst(req_gb_rst),
        .req_mem_init(req_mem_init), .req_len(req_len), .req_addr(req_addr),
        .req_error(req_error), .req_done_request(req_done_request),
        .tx_data(tx_data), .tx_mask(tx_mask), .tx_valid(tx_valid), .tx_ready(tx_ready4),
        .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready), .rx_last(rx_last4),
        .rx_error(rx_error4), .rx_stall(rx_stall4), .rx_addr(rx_addr4), .wr_done(wr_done4),
        .bd_instruction_req(bd_instruction_req4), .bd_instruction_ready(bd_instruction_ready),
        .bd_command(bd_command4), .bd_address(bd_address4), .bd_data_len(bd_data_len4),
        .bd_wdata(bd_wdata4), .bd_wdata_mask(bd_wdata_mask4), .bd_wdata_ready(bd_wdata_ready),
        .bd_rdata_valid(bd_rdata_valid), .bd_rdata(bd_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_request(input logic rw_n, input logic target, input logic typ,
                              input logic gb, input logic init, input int len,
                              input logic [30:0] addr, input logic [1:0] err, input logic done);
        req_rw_n = rw_n; req_target = target; req_type = typ;
        req_gb_rst = gb; req_mem_init = init; req_len = LEN_W'(len);
        req_addr = addr; req_error = err; req_done_request = done;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic issue();
        bd_instruction_ready = 1'b1;
        tick();
        bd_instruction_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_ctl"}, 32'({tx_ready, rx_valid, rx_last, rx_stall, wr_done, bd_instruction_req}), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rx_err_addr"}, 32'({rx_error, rx_addr}), 32'd0);
        chk({tag, "_bd_cmd"}, 32'(bd_command), 32'd0);
        chk({tag, "_bd_addr"}, bd_address, 32'd0);
        chk({tag, "_bd_len"}, 32'(bd_data_len), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n8, n4, cyc, idle;
        logic [7:0] cmd_core_exp [3];
        logic [4:0] cmd_in [3];

        reset_n = 1'b0;
        req_valid = 0; req_rw_n = 0; req_target = 0; req_type = 0; req_gb_rst = 0;
        req_mem_init = 0; req_len = '0; req_addr = '0; req_error = '0; req_done_request = 0;
        tx_data = '0; tx_mask = '0; tx_valid = 0; rx_ready = 0;
        bd_instruction_ready = 0; bd_wdata_ready = 1; bd_rdata_valid = 0; bd_rdata = '0;
        #22;
        check_quiet("reset");
        reset_n = 1'b1;
        tick();

        // ---- array write, len=3, done_request=1
        do_request(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 31'h100, 2'b00, 1'b1);
        chk("wr_instr_req", 32'(bd_instruction_req), 32'd1);
        chk("wr_cmd", 32'(bd_command), 32'h04);
        chk("wr_addr", bd_address, 32'h0000_0100);
        chk("wr_len", 32'(bd_data_len), 32'd3);
        chk("wr_req_ready_busy", 32'(req_ready), 32'd0);
        chk("wr_tx_ready_issue", 32'(tx_ready), 32'd0);
        issue();
        chk("wr_instr_req_drop", 32'(bd_instruction_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_data = DATA_W'(16'h1000 + i); tx_mask = 2'b11;
            #1;
            chk("wr_tx_ready", 32'(tx_ready), 32'd1);
            chk("wr_bd_wdata", 32'(bd_wdata), 32'(16'h1000 + i));
            chk("wr_bd_mask", 32'(bd_wdata_mask), 32'd3);
            chk("wr_done_early", 32'(wr_done), 32'd0);
            tick();
        end
        tx_valid = 1'b0; tx_data = '0; tx_mask = '0;
        chk("wr_done_pulse", 32'(wr_done), 32'd1);
        chk("wr_back_idle", 32'(req_ready), 32'd1);
        tick();
        chk("wr_done_once", 32'(wr_done), 32'd0);

        // ---- array read, len=7, RX stalled while 8 beats stream (both FIFO depths)
        do_request(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7, 31'h200, 2'b00, 1'b0);
        chk("rd_cmd", 32'(bd_command), 32'h08);
        issue();
        rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bd_rdata_valid = 1'b1; bd_rdata = DATA_W'(16'hA000 + i);
            tick();
        end
        bd_rdata_valid = 1'b0; bd_rdata = '0;
        chk("rd8_no_ovf", 32'(rx_error), 32'h0);
        chk("rd4_ovf", 32'(rx_error4), 32'h2);
        rx_ready = 1'b1;
        n8 = 0; n4 = 0; cyc = 0;
        while ((n8 < 8 || n4 < 8) && cyc < 200) begin
            if (n8 < 8 && rx_valid) begin
                chk("rd8_data", 32'(rx_data), 32'(16'hA000 + n8));
                chk("rd8_err", 32'(rx_error), 32'h0);
                chk("rd8_last", 32'(rx_last), 32'(n8 == 7));
                chk("rd8_addr", 32'(rx_addr), 32'((32'h200 + n8) & 1));
                n8++;
            end
            if (n4 < 8 && rx_valid4) begin
                chk("rd4_data", 32'(rx_data4), (n4 < 4) ? 32'(16'hA000 + n4) : 32'd0);
                chk("rd4_err", 32'(rx_error4), 32'h2);
                chk("rd4_stall", 32'(rx_stall4), 32'(n4 >= 4));
                chk("rd4_last", 32'(rx_last4), 32'(n4 == 7));
                n4++;
            end
            tick();
            cyc++;
        end
        chk("rd8_beats", 32'(n8), 32'd8);
        chk("rd4_beats", 32'(n4), 32'd8);
        chk("rd8_idle", 32'(req_ready), 32'd1);
        chk("rd4_idle", 32'({req_ready4, rx_stall4, rx_error4}), 32'b1000);
        rx_ready = 1'b0;

        // ---- read len=1, controller delivers 1 beat then stalls
        do_request(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 31'h201, 2'b00, 1'b0);
        issue();
        rx_ready = 1'b1;
        bd_rdata_valid = 1'b1; bd_rdata = 16'h1234;
        tick();
        bd_rdata_valid = 1'b0; bd_rdata = '0;
        chk("to_beat0_valid", 32'(rx_valid), 32'd1);
        chk("to_beat0_data", 32'(rx_data), 32'h1234);
        chk("to_beat0_addr", 32'(rx_addr), 32'd1);
        chk("to_beat0_last_stall", 32'({rx_last, rx_stall}), 32'd0);
        tick();
        idle = 1;
        while (!rx_stall && idle < 60) begin
            chk("to_no_early_valid", 32'(rx_valid), 32'd0);
            tick();
            idle++;
        end
        chk("to_idle_cycles", 32'(idle), 32'(1 + MARGIN + 1));
        chk("to_synth_valid", 32'(rx_valid), 32'd1);
        chk("to_synth_data", 32'(rx_data), 32'd0);
        chk("to_synth_err", 32'(rx_error), 32'h2);
        chk("to_synth_last", 32'(rx_last), 32'd1);
        chk("to_synth_addr", 32'(rx_addr), 32'd0);
        tick();
        chk("to_back_idle", 32'({req_ready, rx_stall, rx_valid}), 32'b100);
        chk("to_err_cleared", 32'(rx_error), 32'h0);
        rx_ready = 1'b0;

        // ---- MRR with delayed instruction accept, error code carried through
        do_request(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 31'h0ABCDE, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("mrr_req_held", 32'(bd_instruction_req), 32'd1);
            chk("mrr_cmd", 32'(bd_command), 32'h02);
            chk("mrr_addr", bd_address, 32'h000A_BCDE);
            tick();
        end
        issue();
        rx_ready = 1'b1;
        bd_rdata_valid = 1'b1; bd_rdata = 16'h5A5A;
        tick();
        bd_rdata_valid = 1'b0; bd_rdata = '0;
        chk("mrr_data", 32'(rx_data), 32'h5A5A);
        chk("mrr_err", 32'(rx_error), 32'h1);
        chk("mrr_last", 32'({rx_valid, rx_last}), 32'b11);
        tick();
        chk("mrr_idle", 32'(req_ready), 32'd1);
        rx_ready = 1'b0;

        // ---- command table: {rw_n, target, type, gb_rst, mem_init} -> code (len=0 writes)
        cmd_in[0] = 5'b01110; cmd_core_exp[0] = 8'h80;  // global reset
        cmd_in[1] = 5'b01100; cmd_core_exp[1] = 8'h01;  // MRW
        cmd_in[2] = 5'b01000; cmd_core_exp[2] = 8'h00;  // unmapped (core 0xE0)
        for (int k = 0; k < 3; k++) begin
            do_request(cmd_in[k][4], cmd_in[k][3], cmd_in[k][2], cmd_in[k][1], cmd_in[k][0],
                       0, 31'h40, 2'b00, 1'b0);
            chk("tbl_cmd", 32'(bd_command), 32'(cmd_core_exp[k]));
            issue();
            tx_valid = 1'b1; tx_data = 16'h00FF;
            tick();
            tx_valid = 1'b0; tx_data = '0;
            chk("tbl_no_wr_done", 32'(wr_done), 32'd0);
            chk("tbl_idle", 32'(req_ready), 32'd1);
        end

        // ---- reset during write beat 2 of 4
        do_request(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 31'h300, 2'b00, 1'b1);
        issue();
        tx_valid = 1'b1; tx_data = 16'h0001;
        tick();
        tx_data = 16'h0002;
        #2;
        reset_n = 1'b0;
        tx_valid = 1'b0; tx_data = '0; tx_mask = '0;
        #1;
        check_quiet("midrst");
        chk("midrst_bd_wdata", 32'({bd_wdata, bd_wdata_mask}), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_wr_done", 32'(wr_done), 32'd0);
        end
        chk("midrst_idle", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
